packet_buffer_read_arbiter: RTL and testbench
=============================================

PACKET_BUFFER_READ_ARBITER -- requirements
Module: packet_buffer_read_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_SIZE, default 4096: depth of the shared packet buffer, in words.
REQ-002 The block SHALL have parameter WORD_LEN, default 8: read data width in bits.
REQ-003 The block SHALL have parameter MAX_INFLIGHT, default 4: depth of the outstanding-read tag FIFO (power of two, 2..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports req_a and req_b, input, 1 bit each: read request from requester A / B.
REQ-007 The block SHALL have ports addr_a and addr_b, input, clog2(RAM_SIZE) bits each: read address from requester A / B.
REQ-008 The block SHALL have ports gnt_a and gnt_b, output, 1 bit each: the request was accepted this cycle.
REQ-009 The block SHALL have ports ready_a and ready_b, output, 1 bit each: read data valid for requester A / B.
REQ-010 The block SHALL have ports out_a and out_b, output, WORD_LEN bits each: read data for requester A / B.
REQ-011 The block SHALL have port ram_read_req, output, 1 bit: read strobe to the packet buffer RAM driver.
REQ-012 The block SHALL have port ram_read_addr, output, clog2(RAM_SIZE) bits: address to the RAM driver.
REQ-013 The block SHALL have port ram_read_ready, input, 1 bit: RAM driver data valid; responses return in request order.
REQ-014 The block SHALL have port ram_read_out, input, WORD_LEN bits: RAM driver read data.
REQ-015 The block SHALL have port err, output, 1 bit: sticky protocol error flag.

Function
REQ-016 Grant SHALL be combinational in the request cycle: ram_read_req = gnt_a | gnt_b, with ram_read_addr taken from the granted requester (addr_a when neither is granted).
REQ-017 At most one of gnt_a and gnt_b SHALL be high in any cycle; a grant requires the matching req high and the tag FIFO not full.
REQ-018 When both requesters are active, a registered round-robin pointer SHALL select the winner; after each grant the pointer moves to the other requester; a single active requester SHALL always win.
REQ-019 Each grant SHALL push the winner's ID (0 = A, 1 = B) into the tag FIFO.
REQ-020 Each ram_read_ready pulse SHALL pop the FIFO head and, in the same cycle, assert ready_a or ready_b according to the popped ID.
REQ-021 out_a and out_b SHALL both carry ram_read_out every cycle; only the ready strobes are steered.
REQ-022 When the FIFO is full, both grants SHALL be 0 even if a pop occurs in the same cycle; requesters hold req until they see gnt.
REQ-023 A simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged and preserve ordering.
REQ-024 ram_read_ready while the FIFO is empty SHALL assert no ready strobe and SHALL set err until the next reset.
REQ-025 FIFO read and write pointers SHALL wrap modulo MAX_INFLIGHT; occupancy SHALL be a clog2(MAX_INFLIGHT)+1-bit counter.

Reset
REQ-026 On reset, the FIFO SHALL be emptied, the round-robin pointer set to A, and err cleared; grants are suppressed during the reset cycle.
REQ-027 After reset the combinational outputs SHALL follow their inputs: gnt_a, gnt_b, ram_read_req, ready_a and ready_b are 0 when req_a, req_b and ram_read_ready are 0.
REQ-028 A reset in the middle of an operation SHALL discard all outstanding tags; the RAM driver SHALL be reset in the same cycle so that no stale responses arrive.

Configuration
REQ-029 With macro PKTBUF_ARB_FIXED_PRIORITY_EN defined, requester A SHALL always win ties and the round-robin pointer SHALL be omitted; without the macro, round-robin per REQ-018 applies.

Verification
REQ-030 req_a only, addr_a = 0..7, RAM latency 2: gnt_a every cycle, eight ready_a pulses carrying RAM[0..7] in order, ready_b never asserted.
REQ-031 req_a and req_b held high, addr_a = 10, addr_b = 20: grants alternate A, B, A, B after reset; ready pulses alternate likewise, with out data RAM[10] and RAM[20].
REQ-032 MAX_INFLIGHT = 4, RAM responses withheld: four grants then gnt = 0; one ram_read_ready pop allows exactly one further grant in the next cycle.
REQ-033 ram_read_ready pulsed with the FIFO empty: no ready strobe, err = 1 and held; reset returns err to 0.
REQ-034 Reset asserted with 3 reads outstanding (RAM driver also reset): FIFO empty, the next request pair grants A first.
REQ-035 PKTBUF_ARB_FIXED_PRIORITY_EN defined, both requesters held high: gnt_a every cycle, gnt_b never.

Source files
------------

// File: rtl/packet_buffer_read_arbiter.sv
// Two-requester read arbiter for a shared packet buffer: grants one read per cycle and
// steers in-order RAM responses back via a tag FIFO. Define PKTBUF_ARB_FIXED_PRIORITY_EN for A-wins-ties.
module packet_buffer_read_arbiter #(
    parameter int unsigned RAM_SIZE     = 4096,
    parameter int unsigned WORD_LEN     = 8,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_a,
    input  logic                        req_b,
    input  logic [$clog2(RAM_SIZE)-1:0] addr_a,
    input  logic [$clog2(RAM_SIZE)-1:0] addr_b,
    output logic                        gnt_a,
    output logic                        gnt_b,
    output logic                        ready_a,
    output logic                        ready_b,
    output logic [WORD_LEN-1:0]         out_a,
    output logic [WORD_LEN-1:0]         out_b,
    output logic                        ram_read_req,
    output logic [$clog2(RAM_SIZE)-1:0] ram_read_addr,
    input  logic                        ram_read_ready,
    input  logic [WORD_LEN-1:0]         ram_read_out,
    output logic                        err
);

    localparam int unsigned PW = $clog2(MAX_INFLIGHT);
    localparam int unsigned CW = PW + 1;

    logic          tags_q [MAX_INFLIGHT];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic          full, empty, push, pop, head_id;

    assign full    = (count_q == CW'(MAX_INFLIGHT));
    assign empty   = (count_q == '0);
    assign head_id = tags_q[rd_ptr_q];

`ifdef PKTBUF_ARB_FIXED_PRIORITY_EN
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset && !full) begin
            gnt_a = req_a;
            gnt_b = req_b && !req_a;
        end
    end
`else
    // rr_q = 0 favours A on a tie, 1 favours B
    logic rr_q, rr_d;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset && !full) begin
            if (req_a && req_b) begin
                gnt_a = !rr_q;
                gnt_b = rr_q;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_a) begin
            rr_d = 1'b1;
        end else if (gnt_b) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign push          = gnt_a | gnt_b;
    assign ram_read_req  = push;
    assign ram_read_addr = gnt_b ? addr_b : addr_a;

    // A response with nothing outstanding is a protocol error, not a pop
    assign pop     = ram_read_ready && !empty;
    assign ready_a = pop && !head_id;
    assign ready_b = pop && head_id;
    assign out_a   = ram_read_out;
    assign out_b   = ram_read_out;
    assign err     = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (ram_read_ready && empty);
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tags_q[wr_ptr_q] <= gnt_b;
        end
    end

endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// Directed bench for packet_buffer_read_arbiter; the bench itself plays the RAM driver.
module tb_packet_buffer_read_arbiter;

`ifdef PKTBUF_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic [11:0] addr_a, addr_b;
    logic        gnt_a, gnt_b, ready_a, ready_b;
    logic [7:0]  out_a, out_b;
    logic        ram_read_req;
    logic [11:0] ram_read_addr;
    logic        ram_read_ready;
    logic [7:0]  ram_read_out;
    logic        err;

    int total = 0;
    int bad   = 0;

    packet_buffer_read_arbiter #(
        .RAM_SIZE(4096),
        .WORD_LEN(8),
        .MAX_INFLIGHT(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .addr_a(addr_a), .addr_b(addr_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .ready_a(ready_a), .ready_b(ready_b),
        .out_a(out_a), .out_b(out_b),
        .ram_read_req(ram_read_req), .ram_read_addr(ram_read_addr),
        .ram_read_ready(ram_read_ready), .ram_read_out(ram_read_out),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] memv(input int a);
        return 8'(a * 7 + 3);
    endfunction

    // Which requester wins the c-th cycle of a tie that starts right after reset
    function automatic bit win_a(input int c);
        return FIXED ? 1'b1 : (c % 2 == 0);
    endfunction

    task automatic idle_inputs();
        req_a = 0; req_b = 0; addr_a = '0; addr_b = '0;
        ram_read_ready = 0; ram_read_out = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; idle_inputs();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst_err", err, 0);
        chk("rst_gnt", {gnt_a, gnt_b, ram_read_req}, 0);
        chk("rst_rdy", {ready_a, ready_b}, 0);

        // A only, addresses 0..7, responses two cycles after each grant
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            req_a = (c < 8); addr_a = 12'(c);
            ram_read_ready = (c >= 2);
            ram_read_out = (c >= 2) ? memv(c - 2) : 8'h00;
            #1;
            chk("a_gnt_a", gnt_a, (c < 8));
            chk("a_gnt_b", gnt_b, 0);
            chk("a_req", ram_read_req, (c < 8));
            if (c < 8) chk("a_addr", ram_read_addr, c);
            chk("a_rdy_a", ready_a, (c >= 2));
            chk("a_rdy_b", ready_b, 0);
            if (c >= 2) chk("a_out", out_a, memv(c - 2));
        end
        chk("a_err", err, 0);

        // Both held: alternation (or A-always with fixed priority), latency 1
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            req_a = (c < 6); req_b = (c < 6);
            addr_a = 12'd10; addr_b = 12'd20;
            ram_read_ready = (c >= 1);
            ram_read_out = (c >= 1) ? memv(win_a(c - 1) ? 10 : 20) : 8'h00;
            #1;
            chk("rr_gnt_a", gnt_a, (c < 6) && win_a(c));
            chk("rr_gnt_b", gnt_b, (c < 6) && !win_a(c));
            if (c < 6) chk("rr_addr", ram_read_addr, win_a(c) ? 10 : 20);
            chk("rr_rdy_a", ready_a, (c >= 1) && win_a(c - 1));
            chk("rr_rdy_b", ready_b, (c >= 1) && !win_a(c - 1));
            if (c >= 1) chk("rr_out_a", out_a, ram_read_out);
            if (c >= 1) chk("rr_out_b", out_b, memv(win_a(c - 1) ? 10 : 20));
        end

        // Backpressure: four grants, stall, pop while full grants nothing, one grant after
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            req_a = 1; addr_a = 12'd5;
            ram_read_ready = (c == 5); ram_read_out = 8'h5A;
            #1;
            chk("full_gnt_a", gnt_a, (c < 4) || (c == 6));
            chk("full_req", ram_read_req, (c < 4) || (c == 6));
            chk("full_rdy_a", ready_a, (c == 5));
        end

        // Response with nothing outstanding
        do_reset();
        ram_read_ready = 1; ram_read_out = 8'hEE;
        #1;
        chk("err_rdy", {ready_a, ready_b}, 0);
        chk("err_pre", err, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ram_read_ready = 0;
            #1;
            chk("err_sticky", err, 1);
        end
        do_reset();
        #1;
        chk("err_clr", err, 0);
        chk("err_comb0", {gnt_a, gnt_b, ram_read_req, ready_a, ready_b}, 0);

        // Reset with three reads outstanding
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            req_a = 1; addr_a = 12'd7;
            #1;
            chk("mid_gnt_a", gnt_a, 1);
        end
        @(negedge clk);
        reset = 1; req_a = 1; req_b = 1;
        #1;
        chk("mid_rst_gnt", {gnt_a, gnt_b, ram_read_req}, 0);
        @(negedge clk);
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            req_a = 1; req_b = 1; addr_a = 12'd1; addr_b = 12'd2;
            #1;
            chk("post_gnt_a", gnt_a, (c < 4) && win_a(c));
            chk("post_gnt_b", gnt_b, (c < 4) && !win_a(c));
        end

        @(negedge clk);
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
